// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the multi-cycle serial adder/subtractor.
// The FSM state encoding lives here so every file agrees on it.
package serial_addsub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/serial_addsub_ripple.sv
// Combinational SLICE-bit ripple-carry segment built from single-bit full adders.
// It also exposes the carry into its top bit, so the caller can detect signed overflow.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module ripple_slice_adder
    import serial_addsub_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    // c[i] is the carry into bit i; c[SLICE] leaves the slice.
    logic [SLICE:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[SLICE];
    assign c_msb = c[SLICE-1];

endmodule

// File: rtl/serial_addsub.sv
// Parametrised add/subtract that walks the operands one SLICE-bit segment per clock,
// carrying between segments in a register so the combinational path is one slice long.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    state_t          state;
    logic [IDXW-1:0] idx;
    logic            carry;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;

    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] slice_s;
    logic             slice_cout;
    logic             slice_cmsb;

    assign slice_a = opa[int'(idx) * SLICE +: SLICE];
    assign slice_b = opb[int'(idx) * SLICE +: SLICE];

    ripple_slice_adder #(.SLICE(SLICE)) u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .cin   (carry),
        .s     (slice_s),
        .cout  (slice_cout),
        .c_msb (slice_cmsb)
    );

    assign ready = (state == IDLE);
    assign done  = (state == DONE);

    // Subtraction is A + ~B + ~Cin, so B is inverted once at accept and the
    // carry register starts at Cin^sub; the slice datapath is then add-only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            V     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= A;
                        opb   <= sub ? ~B : B;
                        carry <= Cin ^ sub;
                        idx   <= '0;
                        S     <= '0;
                        Cout  <= 1'b0;
                        V     <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    S[int'(idx) * SLICE +: SLICE] <= slice_s;
                    carry <= slice_cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        Cout  <= slice_cout;
                        V     <= slice_cout ^ slice_cmsb;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: four parameterisations each checked every cycle against an
// arithmetic reference model, plus directed literal cases on the 16/4 instance.
module tb_serial_addsub;

    localparam int NCFG = 4;
    localparam int CFG_W [NCFG] = '{16, 8, 8, 32};
    localparam int CFG_S [NCFG] = '{4, 8, 1, 4};

    logic clk = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    function automatic logic [63:0] low_mask(input int n);
        if (n >= 64) return '1;
        return (64'd1 << n) - 64'd1;
    endfunction

    // Reference arithmetic: result modulo 2^w, carry / not-borrow, and signed overflow
    // judged by whether the exact signed answer fits in w bits.
    function automatic void ref_op(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic sb, input logic ci,
                                   output logic [63:0] s, output logic c, output logic v);
        logic [63:0] m;
        longint half;
        longint sa;
        longint sbv;
        longint ideal;
        m    = low_mask(w);
        half = longint'(64'd1 << (w - 1));
        sa   = longint'(a);
        sbv  = longint'(b);
        if (sa >= half) sa = sa - 2 * half;
        if (sbv >= half) sbv = sbv - 2 * half;
        if (!sb) begin
            s     = (a + b + 64'(ci)) & m;
            c     = ((a + b + 64'(ci)) > m);
            ideal = sa + sbv + longint'(ci);
        end else begin
            s     = (a - b - 64'(ci)) & m;
            c     = (a >= b + 64'(ci));
            ideal = sa - sbv - longint'(ci);
        end
        v = (ideal >= half) || (ideal < -half);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W  = CFG_W[g];
        localparam int SL = CFG_S[g];
        localparam int NS = W / SL;

        logic         rst = 1'b1;
        logic         start = 1'b0;
        logic         sub = 1'b0;
        logic         cin = 1'b0;
        logic [W-1:0] a = '0;
        logic [W-1:0] b = '0;
        logic         ready;
        logic         done;
        logic [W-1:0] s;
        logic         cout;
        logic         v;
        bit           finished = 1'b0;
        string        tag = "";

        // Model: age counts edges since accept (0 = idle); outputs follow from it.
        int          age = 0;
        bit          armed = 1'b0;
        logic [63:0] pend_s = '0;
        logic        pend_c = 1'b0;
        logic        pend_v = 1'b0;
        logic [63:0] exp_s = '0;
        logic        exp_c = 1'b0;
        logic        exp_v = 1'b0;

        serial_addsub #(.WIDTH(W), .SLICE(SL)) dut (
            .clk   (clk),
            .rst   (rst),
            .start (start),
            .sub   (sub),
            .A     (a),
            .B     (b),
            .Cin   (cin),
            .ready (ready),
            .done  (done),
            .S     (s),
            .Cout  (cout),
            .V     (v)
        );

        always @(posedge clk) begin
            if (rst) begin
                age   = 0;
                exp_s = '0;
                exp_c = 1'b0;
                exp_v = 1'b0;
                armed = 1'b1;
            end else if (age == 0) begin
                if (start) begin
                    ref_op(W, 64'(a), 64'(b), sub, cin, pend_s, pend_c, pend_v);
                    age   = 1;
                    exp_s = '0;
                    exp_c = 1'b0;
                    exp_v = 1'b0;
                end
            end else if (age <= NS) begin
                age   = age + 1;
                exp_s = pend_s & low_mask(SL * (age - 1));
                if (age == NS + 1) begin
                    exp_c = pend_c;
                    exp_v = pend_v;
                end
            end else begin
                age = 0;
            end
        end

        always @(negedge clk) begin
            if (armed) begin
                checkOutput({tag, " ready"}, 64'(ready), 64'(age == 0));
                checkOutput({tag, " done"}, 64'(done), 64'(age == NS + 1));
                checkOutput({tag, " S"}, 64'(s), exp_s);
                checkOutput({tag, " Cout"}, 64'(cout), 64'(exp_c));
                checkOutput({tag, " V"}, 64'(v), 64'(exp_v));
            end
        end

        task automatic applyStimulus(input int cycles);
            for (int i = 0; i < cycles; i++) begin
                @(posedge clk);
                #1;
                rst   = ($urandom_range(0, 79) == 0);
                start = ($urandom_range(0, 3) != 0);
                sub   = 1'($urandom_range(0, 1));
                cin   = 1'($urandom_range(0, 1));
                a     = W'($urandom);
                b     = W'($urandom);
                if ($urandom_range(0, 7) == 0) a = '1;
                if ($urandom_range(0, 7) == 0) b = '0;
            end
            @(posedge clk);
            #1;
            rst   = 1'b0;
            start = 1'b0;
        endtask

        if (g == 0) begin : g_drv
            task automatic runOp(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tsub, input logic tcin,
                                 input logic [W-1:0] es, input logic ec, input logic ev);
                int lat;
                @(posedge clk);
                #1;
                checkOutput({name, " ready before"}, 64'(ready), 64'd1);
                a     = ta;
                b     = tb;
                sub   = tsub;
                cin   = tcin;
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                lat   = 0;
                while (done !== 1'b1 && lat < 4 * NS) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                checkOutput({name, " latency"}, 64'(lat), 64'd4);
                checkOutput({name, " S"}, 64'(s), 64'(es));
                checkOutput({name, " Cout"}, 64'(cout), 64'(ec));
                checkOutput({name, " V"}, 64'(v), 64'(ev));
                @(posedge clk);
                #1;
            endtask

            initial begin
                int pulses;
                logic [W-1:0] seen;
                tag = "w16_s4";
                rst = 1'b1;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                checkOutput("reset ready", 64'(ready), 64'd1);
                checkOutput("reset done", 64'(done), 64'd0);
                checkOutput("reset S", 64'(s), 64'd0);
                checkOutput("reset Cout", 64'(cout), 64'd0);
                checkOutput("reset V", 64'(v), 64'd0);

                runOp("add basic", 16'h1234, 16'h0FED, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b0);
                runOp("add ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
                runOp("add chain", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
                runOp("sub neg", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
                runOp("sub ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

                // A second start two cycles into an operation must be dropped.
                a = 16'h0001; b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
                @(posedge clk);
                #1;
                a = 16'hAAAA; b = 16'h5555; sub = 1'b1; cin = 1'b1; start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
                pulses = 0;
                seen   = '0;
                for (int i = 0; i < 12; i++) begin
                    if (done === 1'b1) begin
                        pulses++;
                        seen = s;
                    end
                    @(posedge clk);
                    #1;
                end
                checkOutput("busy pulses", 64'(pulses), 64'd1);
                checkOutput("busy S", 64'(seen), 64'h0002);

                // Reset while idx=2 abandons the operation without a done pulse.
                a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                checkOutput("midrst S", 64'(s), 64'd0);
                checkOutput("midrst Cout", 64'(cout), 64'd0);
                checkOutput("midrst V", 64'(v), 64'd0);
                checkOutput("midrst done", 64'(done), 64'd0);
                checkOutput("midrst ready", 64'(ready), 64'd1);
                pulses = 0;
                for (int i = 0; i < 10; i++) begin
                    if (done === 1'b1) pulses++;
                    @(posedge clk);
                    #1;
                end
                checkOutput("midrst pulses", 64'(pulses), 64'd0);
                runOp("after reset", 16'h0123, 16'h0456, 1'b0, 1'b0, 16'h0579, 1'b0, 1'b0);

                applyStimulus(300);
                finished = 1'b1;
            end
        end else begin : g_drv
            initial begin
                tag = $sformatf("w%0d_s%0d", W, SL);
                rst = 1'b1;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                applyStimulus(400);
                finished = 1'b1;
            end
        end
    end

    initial begin
        int  cyc;
        bit  all_done;
        cyc      = 0;
        all_done = 1'b0;
        while (!all_done && cyc < 20000) begin
            @(posedge clk);
            cyc++;
            all_done = g_cfg[0].finished && g_cfg[1].finished &&
                       g_cfg[2].finished && g_cfg[3].finished;
        end
        if (!all_done) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout actual=%0d cycles required=all stimulus finished", cyc);
        end
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
